// File: rtl/afu_arb_pkg.sv
// Shared constants and mdata tag helpers for the AFU request arbiter.
// The client id occupies the top bits of the shared mdata field.
package afu_arb_pkg;

   localparam int OUT_W = 8;

   function automatic int idw(input int ncli);
      return (ncli > 1) ? $clog2(ncli) : 1;
   endfunction

   function automatic logic [31:0] tag_pack(input logic [31:0] id, input logic [31:0] lo, input int lo_w);
      return (id << lo_w) | lo;
   endfunction

   function automatic int tag_id(input logic [31:0] mdata, input int lo_w);
      return int'(mdata >> lo_w);
   endfunction

endpackage

// File: rtl/afu_rr_pick.sv
// Round-robin picker: first eligible client at or after ptr, wrapping
// modulo NCLI (NCLI is a power of two so the index wraps naturally).
module afu_rr_pick
   import afu_arb_pkg::*;
#(
   parameter  int NCLI = 2,
   localparam int IDW  = idw(NCLI)
)(
   input  logic [NCLI-1:0] eligible,
   input  logic [IDW-1:0]  ptr,
   output logic [NCLI-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            valid
);

   logic [IDW-1:0] cand;

   // Scan clients in priority order starting at ptr.
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = 0; i < NCLI; i++) begin
         cand = ptr + IDW'(i);
         if (!valid && eligible[cand]) begin
            grant[cand] = 1'b1;
            idx         = cand;
            valid       = 1'b1;
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/afu_req_arbiter.sv
// Shares one host read/write request channel between NCLI clients with
// independent round-robin rd/wr arbitration. Optional macro: AFU_ARB_STATS_EN.
module afu_req_arbiter
   import afu_arb_pkg::*;
#(
   parameter  int ADDR_LMT    = 20,
   parameter  int MDATA       = 14,
   parameter  int CACHE_WIDTH = 512,
   parameter  int NCLI        = 2,
   parameter  int MAX_OUT     = 64,
   localparam int IDW         = idw(NCLI),
   localparam int LO          = MDATA - IDW
)(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NCLI-1:0]             c_rd_valid,
   input  logic [NCLI*ADDR_LMT-1:0]    c_rd_addr,
   input  logic [NCLI*LO-1:0]          c_rd_mdata,
   output logic [NCLI-1:0]             c_rd_ack,
   output logic [NCLI-1:0]             c_rd_rsp_valid,
   output logic [LO-1:0]               c_rd_rsp_mdata,
   output logic [CACHE_WIDTH-1:0]      c_rd_rsp_data,
   input  logic [NCLI-1:0]             c_wr_valid,
   input  logic [NCLI*ADDR_LMT-1:0]    c_wr_addr,
   input  logic [NCLI*LO-1:0]          c_wr_mdata,
   input  logic [NCLI*CACHE_WIDTH-1:0] c_wr_data,
   output logic [NCLI-1:0]             c_wr_ack,
   output logic [NCLI*2-1:0]           c_wr_rsp_cnt,
   output logic [ADDR_LMT-1:0]         rd_req_addr,
   output logic [MDATA-1:0]            rd_req_mdata,
   output logic                        rd_req_en,
   input  logic                        rd_req_almostfull,
   input  logic                        rd_rsp_valid,
   input  logic [MDATA-1:0]            rd_rsp_mdata,
   input  logic [CACHE_WIDTH-1:0]      rd_rsp_data,
   output logic [ADDR_LMT-1:0]         wr_req_addr,
   output logic [MDATA-1:0]            wr_req_mdata,
   output logic [CACHE_WIDTH-1:0]      wr_req_data,
   output logic                        wr_req_en,
   input  logic                        wr_req_almostfull,
   input  logic                        wr_rsp0_valid,
   input  logic [MDATA-1:0]            wr_rsp0_mdata,
   input  logic                        wr_rsp1_valid,
   input  logic [MDATA-1:0]            wr_rsp1_mdata,
   output logic                        idle,
   output logic [NCLI*32-1:0]          stat_rd_gnt,
   output logic [NCLI*32-1:0]          stat_wr_gnt
);

   logic [OUT_W-1:0] rd_out [NCLI];
   logic [OUT_W-1:0] wr_out [NCLI];
   logic [OUT_W-1:0] rd_nxt [NCLI];
   logic [OUT_W-1:0] wr_nxt [NCLI];
   logic [NCLI-1:0]  rd_elig, wr_elig, rd_pick, wr_pick;
   logic             rd_pick_v, wr_pick_v, rd_fire, wr_fire, idle_nxt;
   logic [IDW-1:0]   rd_idx, wr_idx, rd_ptr, wr_ptr;

   // Responses beyond the outstanding count are dropped rather than underflowing.
   function automatic logic [OUT_W-1:0] out_next(input logic [OUT_W-1:0] cur, input logic inc,
                                                 input logic [1:0] dec);
      logic [OUT_W:0] up;
      up = {1'b0, cur} + {{OUT_W{1'b0}}, inc};
      if ({{(OUT_W-1){1'b0}}, dec} > up) return '0;
      else return OUT_W'(up - {{(OUT_W-1){1'b0}}, dec});
   endfunction

   // A client competes only while below its outstanding cap.
   always_comb begin
      rd_elig = '0;
      wr_elig = '0;
      for (int k = 0; k < NCLI; k++) begin
         rd_elig[k] = c_rd_valid[k] && (rd_out[k] < OUT_W'(MAX_OUT));
         wr_elig[k] = c_wr_valid[k] && (wr_out[k] < OUT_W'(MAX_OUT));
      end
   end

   afu_rr_pick #(.NCLI(NCLI)) u_rd_pick (.eligible(rd_elig), .ptr(rd_ptr), .grant(rd_pick), .idx(rd_idx), .valid(rd_pick_v));
   afu_rr_pick #(.NCLI(NCLI)) u_wr_pick (.eligible(wr_elig), .ptr(wr_ptr), .grant(wr_pick), .idx(wr_idx), .valid(wr_pick_v));

   assign rd_fire  = rd_pick_v && !rd_req_almostfull && reset_n;
   assign wr_fire  = wr_pick_v && !wr_req_almostfull && reset_n;
   assign c_rd_ack = rd_fire ? rd_pick : '0;
   assign c_wr_ack = wr_fire ? wr_pick : '0;

   assign c_rd_rsp_mdata = rd_rsp_mdata[LO-1:0];
   assign c_rd_rsp_data  = rd_rsp_data;

   // Route responses back to the client named by the mdata tag.
   always_comb begin
      c_rd_rsp_valid = '0;
      c_wr_rsp_cnt   = '0;
      for (int k = 0; k < NCLI; k++) begin
         c_rd_rsp_valid[k] = rd_rsp_valid && (tag_id(32'(rd_rsp_mdata), LO) == k);
         c_wr_rsp_cnt[2*k +: 2] = {1'b0, wr_rsp0_valid && (tag_id(32'(wr_rsp0_mdata), LO) == k)}
                                + {1'b0, wr_rsp1_valid && (tag_id(32'(wr_rsp1_mdata), LO) == k)};
      end
   end

   // Next outstanding counts and the idle condition they imply.
   always_comb begin
      idle_nxt = 1'b1;
      for (int k = 0; k < NCLI; k++) begin
         rd_nxt[k] = out_next(rd_out[k], c_rd_ack[k], {1'b0, c_rd_rsp_valid[k]});
         wr_nxt[k] = out_next(wr_out[k], c_wr_ack[k], c_wr_rsp_cnt[2*k +: 2]);
         if ((rd_nxt[k] != '0) || (wr_nxt[k] != '0)) idle_nxt = 1'b0;
         else idle_nxt = idle_nxt;
      end
   end

   // Outstanding counters and registered idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NCLI; k++) begin
            rd_out[k] <= '0;
            wr_out[k] <= '0;
         end
         idle <= 1'b1;
      end else begin
         for (int k = 0; k < NCLI; k++) begin
            rd_out[k] <= rd_nxt[k];
            wr_out[k] <= wr_nxt[k];
         end
         idle <= idle_nxt;
      end
   end

   // Registered read request and read RR pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_req_en    <= 1'b0;
         rd_req_addr  <= '0;
         rd_req_mdata <= '0;
         rd_ptr       <= '0;
      end else begin
         rd_req_en <= rd_fire;
         if (rd_fire) begin
            rd_req_addr  <= c_rd_addr[rd_idx*ADDR_LMT +: ADDR_LMT];
            rd_req_mdata <= MDATA'(tag_pack(32'(rd_idx), 32'(c_rd_mdata[rd_idx*LO +: LO]), LO));
            rd_ptr       <= rd_idx + IDW'(1);
         end
      end
   end

   // Registered write request and write RR pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_req_en    <= 1'b0;
         wr_req_addr  <= '0;
         wr_req_mdata <= '0;
         wr_req_data  <= '0;
         wr_ptr       <= '0;
      end else begin
         wr_req_en <= wr_fire;
         if (wr_fire) begin
            wr_req_addr  <= c_wr_addr[wr_idx*ADDR_LMT +: ADDR_LMT];
            wr_req_mdata <= MDATA'(tag_pack(32'(wr_idx), 32'(c_wr_mdata[wr_idx*LO +: LO]), LO));
            wr_req_data  <= c_wr_data[wr_idx*CACHE_WIDTH +: CACHE_WIDTH];
            wr_ptr       <= wr_idx + IDW'(1);
         end
      end
   end

`ifdef AFU_ARB_STATS_EN
   logic [31:0] rd_gnt_cnt [NCLI];
   logic [31:0] wr_gnt_cnt [NCLI];

   // Saturating per-client grant counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NCLI; k++) begin
            rd_gnt_cnt[k] <= 32'd0;
            wr_gnt_cnt[k] <= 32'd0;
         end
      end else begin
         for (int k = 0; k < NCLI; k++) begin
            if (c_rd_ack[k] && (rd_gnt_cnt[k] != 32'hFFFF_FFFF)) rd_gnt_cnt[k] <= rd_gnt_cnt[k] + 32'd1;
            if (c_wr_ack[k] && (wr_gnt_cnt[k] != 32'hFFFF_FFFF)) wr_gnt_cnt[k] <= wr_gnt_cnt[k] + 32'd1;
         end
      end
   end

   // Flatten counters onto the stat ports.
   always_comb begin
      stat_rd_gnt = '0;
      stat_wr_gnt = '0;
      for (int k = 0; k < NCLI; k++) begin
         stat_rd_gnt[k*32 +: 32] = rd_gnt_cnt[k];
         stat_wr_gnt[k*32 +: 32] = wr_gnt_cnt[k];
      end
   end
`else
   assign stat_rd_gnt = '0;
   assign stat_wr_gnt = '0;
`endif

endmodule

// File: tb/tb_afu_req_arbiter.sv
// Randomized + directed bench for afu_req_arbiter against a behavioural model
// tracking outstanding counts, RR priority and the expected registered request.
module tb_afu_req_arbiter;

   localparam int NC = 2;
   localparam int AW = 20;
   localparam int MW = 14;
   localparam int LW = 13;
   localparam int CW = 512;
   localparam int MO = 4;

   logic clk = 1'b0, reset_n = 1'b0;
   logic [NC-1:0] c_rd_valid, c_rd_ack, c_rd_rsp_valid, c_wr_valid, c_wr_ack;
   logic [NC*AW-1:0] c_rd_addr, c_wr_addr;
   logic [NC*LW-1:0] c_rd_mdata, c_wr_mdata;
   logic [LW-1:0] c_rd_rsp_mdata;
   logic [CW-1:0] c_rd_rsp_data, rd_rsp_data, wr_req_data;
   logic [NC*CW-1:0] c_wr_data;
   logic [NC*2-1:0] c_wr_rsp_cnt;
   logic [AW-1:0] rd_req_addr, wr_req_addr;
   logic [MW-1:0] rd_req_mdata, wr_req_mdata, rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
   logic rd_req_en, wr_req_en, rd_req_almostfull, wr_req_almostfull;
   logic rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid, idle;
   logic [NC*32-1:0] stat_rd_gnt, stat_wr_gnt;

   int checks = 0, errors = 0;

   afu_req_arbiter #(.ADDR_LMT(AW), .MDATA(MW), .CACHE_WIDTH(CW), .NCLI(NC), .MAX_OUT(MO)) dut (
      .clk(clk), .reset_n(reset_n),
      .c_rd_valid(c_rd_valid), .c_rd_addr(c_rd_addr), .c_rd_mdata(c_rd_mdata), .c_rd_ack(c_rd_ack),
      .c_rd_rsp_valid(c_rd_rsp_valid), .c_rd_rsp_mdata(c_rd_rsp_mdata), .c_rd_rsp_data(c_rd_rsp_data),
      .c_wr_valid(c_wr_valid), .c_wr_addr(c_wr_addr), .c_wr_mdata(c_wr_mdata), .c_wr_data(c_wr_data),
      .c_wr_ack(c_wr_ack), .c_wr_rsp_cnt(c_wr_rsp_cnt),
      .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
      .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
      .rd_rsp_data(rd_rsp_data), .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata),
      .wr_req_data(wr_req_data), .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
      .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata), .wr_rsp1_valid(wr_rsp1_valid),
      .wr_rsp1_mdata(wr_rsp1_mdata), .idle(idle), .stat_rd_gnt(stat_rd_gnt), .stat_wr_gnt(stat_wr_gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model state
   int m_rd_out[NC], m_wr_out[NC], m_rd_ptr, m_wr_ptr;
   logic [NC-1:0] m_rd_ack, m_wr_ack;
   bit m_rd_en, m_wr_en, m_idle;
   logic [AW-1:0] m_rd_addr, m_wr_addr;
   logic [MW-1:0] m_rd_md, m_wr_md;
   logic [CW-1:0] m_wr_data;
   logic [31:0] m_rd_gnt[NC], m_wr_gnt[NC];

   function automatic int rr_winner(input logic [NC-1:0] elig, input int ptr);
      for (int i = 0; i < NC; i++) if (elig[(ptr + i) % NC]) return (ptr + i) % NC;
      return -1;
   endfunction

   function automatic int max0(input int v);
      return (v < 0) ? 0 : v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) begin
         m_rd_out[k] = 0; m_wr_out[k] = 0; m_rd_gnt[k] = 0; m_wr_gnt[k] = 0;
      end
      m_rd_ptr = 0; m_wr_ptr = 0; m_rd_ack = '0; m_wr_ack = '0;
      m_rd_en = 0; m_wr_en = 0; m_idle = 1;
   endtask

   // Compare process: check all outputs every falling edge, then advance the model.
   always @(negedge clk) begin : compare
      logic [NC-1:0] er, ew, erl, ewl, ersp;
      logic [2*NC-1:0] ecnt;
      int rw, ww, c;
      bit any;
      if (!reset_n) begin
         model_reset();
         chk("rst_rd_ack", c_rd_ack, 0);
         chk("rst_wr_ack", c_wr_ack, 0);
         chk("rst_rd_en", rd_req_en, 0);
         chk("rst_wr_en", wr_req_en, 0);
         chk("rst_idle", idle, 1);
      end else begin
         er = '0; ew = '0; ersp = '0; ecnt = '0;
         for (int k = 0; k < NC; k++) begin
            erl[k] = c_rd_valid[k] && (m_rd_out[k] < MO);
            ewl[k] = c_wr_valid[k] && (m_wr_out[k] < MO);
         end
         rw = rd_req_almostfull ? -1 : rr_winner(erl, m_rd_ptr);
         ww = wr_req_almostfull ? -1 : rr_winner(ewl, m_wr_ptr);
         if (rw >= 0) er[rw] = 1'b1;
         if (ww >= 0) ew[ww] = 1'b1;
         if (rd_rsp_valid) ersp[rd_rsp_mdata / (1 << LW)] = 1'b1;
         for (int k = 0; k < NC; k++) begin
            c = ((wr_rsp0_valid && (wr_rsp0_mdata / (1 << LW)) == k) ? 1 : 0)
              + ((wr_rsp1_valid && (wr_rsp1_mdata / (1 << LW)) == k) ? 1 : 0);
            ecnt[2*k +: 2] = 2'(c);
         end
         chk("rd_ack", c_rd_ack, er);
         chk("wr_ack", c_wr_ack, ew);
         chk("rd_rsp_valid", c_rd_rsp_valid, ersp);
         if (rd_rsp_valid) begin
            chk("rd_rsp_mdata", c_rd_rsp_mdata, rd_rsp_mdata % (1 << LW));
            chk("rd_rsp_data", c_rd_rsp_data, rd_rsp_data);
         end
         chk("wr_rsp_cnt", c_wr_rsp_cnt, ecnt);
         chk("rd_req_en", rd_req_en, m_rd_en);
         chk("wr_req_en", wr_req_en, m_wr_en);
         if (m_rd_en) begin
            chk("rd_req_addr", rd_req_addr, m_rd_addr);
            chk("rd_req_mdata", rd_req_mdata, m_rd_md);
         end
         if (m_wr_en) begin
            chk("wr_req_addr", wr_req_addr, m_wr_addr);
            chk("wr_req_mdata", wr_req_mdata, m_wr_md);
            chk("wr_req_data", wr_req_data, m_wr_data);
         end
         chk("idle", idle, m_idle);
`ifdef AFU_ARB_STATS_EN
         chk("stat_rd", stat_rd_gnt, {m_rd_gnt[1], m_rd_gnt[0]});
         chk("stat_wr", stat_wr_gnt, {m_wr_gnt[1], m_wr_gnt[0]});
`else
         chk("stat_rd", stat_rd_gnt, 0);
         chk("stat_wr", stat_wr_gnt, 0);
`endif
         any = 0;
         for (int k = 0; k < NC; k++) begin
            m_rd_out[k] = max0(m_rd_out[k] + int'(er[k]) - int'(ersp[k]));
            m_wr_out[k] = max0(m_wr_out[k] + int'(ew[k]) - int'(ecnt[2*k +: 2]));
            if (m_rd_out[k] != 0 || m_wr_out[k] != 0) any = 1;
            m_rd_gnt[k] += 32'(er[k]);
            m_wr_gnt[k] += 32'(ew[k]);
         end
         m_idle = !any;
         m_rd_en = (rw >= 0);
         m_wr_en = (ww >= 0);
         if (rw >= 0) begin
            m_rd_addr = c_rd_addr[rw*AW +: AW];
            m_rd_md   = MW'(rw * (1 << LW) + int'(c_rd_mdata[rw*LW +: LW]));
            m_rd_ptr  = (rw + 1) % NC;
         end
         if (ww >= 0) begin
            m_wr_addr = c_wr_addr[ww*AW +: AW];
            m_wr_md   = MW'(ww * (1 << LW) + int'(c_wr_mdata[ww*LW +: LW]));
            m_wr_data = c_wr_data[ww*CW +: CW];
            m_wr_ptr  = (ww + 1) % NC;
         end
         m_rd_ack = er;
         m_wr_ack = ew;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic look();
      @(negedge clk); #1;
   endtask

   function automatic logic [CW-1:0] rnd_line();
      logic [CW-1:0] v;
      for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic rand_inputs();
      for (int k = 0; k < NC; k++) begin
         if (!c_rd_valid[k] || m_rd_ack[k]) begin
            c_rd_valid[k] = ($urandom % 4) != 0;
            c_rd_addr[k*AW +: AW] = AW'($urandom);
            c_rd_mdata[k*LW +: LW] = LW'($urandom);
         end
         if (!c_wr_valid[k] || m_wr_ack[k]) begin
            c_wr_valid[k] = ($urandom % 3) != 0;
            c_wr_addr[k*AW +: AW] = AW'($urandom);
            c_wr_mdata[k*LW +: LW] = LW'($urandom);
            c_wr_data[k*CW +: CW] = rnd_line();
         end
      end
      rd_req_almostfull = ($urandom % 8) == 0;
      wr_req_almostfull = ($urandom % 8) == 0;
      rd_rsp_valid  = ($urandom % 3) == 0;
      rd_rsp_mdata  = {1'($urandom), LW'($urandom)};
      rd_rsp_data   = rnd_line();
      wr_rsp0_valid = ($urandom % 3) == 0;
      wr_rsp0_mdata = {1'($urandom), LW'($urandom)};
      wr_rsp1_valid = ($urandom % 4) == 0;
      wr_rsp1_mdata = {1'($urandom), LW'($urandom)};
   endtask

   initial begin : stim
      logic [NC-1:0] t1_exp [4];
      int n_ack, n_en;
      t1_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
      c_rd_valid = '0; c_rd_addr = '0; c_rd_mdata = '0;
      c_wr_valid = '0; c_wr_addr = '0; c_wr_mdata = '0; c_wr_data = '0;
      rd_req_almostfull = 0; wr_req_almostfull = 0;
      rd_rsp_valid = 0; rd_rsp_mdata = '0; rd_rsp_data = '0;
      wr_rsp0_valid = 0; wr_rsp0_mdata = '0; wr_rsp1_valid = 0; wr_rsp1_mdata = '0;
      repeat (3) step();
      reset_n = 1;
      look();
      chk("post_rst_idle", idle, 1);
      chk("post_rst_rd_en", rd_req_en, 0);

      // Two continuous readers alternate 0,1,0,1; the tag bit follows.
      step();
      c_rd_valid = 2'b11;
      c_rd_addr  = {20'hB0001, 20'hA0000};
      c_rd_mdata = {13'h0022, 13'h0011};
      for (int i = 0; i < 4; i++) begin
         look();
         chk("t1_model_ack", m_rd_ack, t1_exp[i]);
         chk("t1_dut_ack", c_rd_ack, t1_exp[i]);
         if (i > 0) chk("t1_tag", rd_req_mdata[13], (i - 1) % 2);
         step();
      end
      c_rd_valid = '0;

      // Tagged read response for client 1.
      rd_rsp_valid = 1; rd_rsp_mdata = 14'h2005; rd_rsp_data = rnd_line();
      look();
      chk("t2_rsp_valid", c_rd_rsp_valid, 2'b10);
      chk("t2_rsp_mdata", c_rd_rsp_mdata, 13'h0005);
      chk("t2_model_cnt1", m_rd_out[1], 1);
      step();
      rd_rsp_valid = 0;

      // Client 0 has 2 outstanding: 2 more acks then capped; client 1 still served.
      c_rd_valid = 2'b01;
      n_ack = 0;
      for (int i = 0; i < 4; i++) begin
         look();
         if (c_rd_ack[0]) n_ack++;
         step();
      end
      chk("t4_acks_before_cap", n_ack, 2);
      chk("t4_model_cnt0", m_rd_out[0], MO);
      c_rd_valid = 2'b11;
      look();
      chk("t4_c1_granted", c_rd_ack, 2'b10);
      step();
      c_rd_valid = 2'b01;
      look();
      chk("t4_c0_capped", c_rd_ack, 2'b00);
      step();
      c_rd_valid = '0;

      // Drain all reads (client 0: 4, client 1: 2).
      for (int i = 0; i < 6; i++) begin
         rd_rsp_valid = 1;
         rd_rsp_mdata = {(i < 4) ? 1'b0 : 1'b1, LW'(i)};
         rd_rsp_data  = rnd_line();
         step();
      end
      rd_rsp_valid = 0;

      // Two writes from client 0, then both write responses in one cycle.
      c_wr_valid = 2'b01; c_wr_data[CW-1:0] = rnd_line();
      for (int i = 0; i < 2; i++) begin
         look();
         chk("t3_wr_ack", c_wr_ack, 2'b01);
         step();
      end
      c_wr_valid = '0;
      look();
      chk("t3_not_idle", idle, 0);
      step();
      wr_rsp0_valid = 1; wr_rsp0_mdata = 14'h0001;
      wr_rsp1_valid = 1; wr_rsp1_mdata = 14'h0002;
      look();
      chk("t3_wr_cnt", c_wr_rsp_cnt[1:0], 2'd2);
      chk("t3_model_cnt", m_wr_out[0], 0);
      step();
      wr_rsp0_valid = 0; wr_rsp1_valid = 0;
      look();
      chk("t3_idle", idle, 1);
      step();

      // almostfull for 10 cycles: only the already-registered request issues.
      c_rd_valid = 2'b11;
      step();
      rd_req_almostfull = 1;
      n_ack = 0; n_en = 0;
      for (int i = 0; i < 10; i++) begin
         look();
         if (c_rd_ack != '0) n_ack++;
         if (rd_req_en) n_en++;
         step();
      end
      chk("t5_no_acks", n_ack, 0);
      chk("t5_one_en", n_en, 1);
      rd_req_almostfull = 0;
      look();
      chk("t5_resume", c_rd_ack, 2'b10);
      step();
      c_rd_valid = '0;

      // Randomized traffic with a mid-burst async reset.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rand_inputs();
         if (cyc == 1500) begin
            c_rd_valid = 2'b11; c_wr_valid = 2'b11;
            rd_req_almostfull = 0; wr_req_almostfull = 0;
            #2 reset_n = 0;
            #1;
            chk("t6_rd_ack", c_rd_ack, 0);
            chk("t6_wr_ack", c_wr_ack, 0);
            chk("t6_rd_en", rd_req_en, 0);
            chk("t6_wr_en", wr_req_en, 0);
            chk("t6_idle", idle, 1);
            chk("t6_stat_rd", stat_rd_gnt, 0);
            chk("t6_stat_wr", stat_wr_gnt, 0);
            step();
            reset_n = 1;
         end
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
